// File: rtl/aes_selftest_pkg.sv
// Shared types and FIPS-197 known-answer data for the AES built-in self-test.
// Contents:
//   keylen_e      - core key-length encoding (00=128, 01=192, 10=256)
//   state_e       - self-test controller FSM states
//   KAT_*         - plaintext, keys and ciphertexts of the FIPS-197 examples
//   lowest_keylen - lowest-index key size set in a 3-bit mask
//   kat_key       - MSB-justified 256-bit key for a key size
//   kat_ct        - expected ciphertext for a key size
package aes_selftest_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10
  } keylen_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SEL      = 4'd1,
    ST_ENC_REQ  = 4'd2,
    ST_ENC_WAIT = 4'd3,
    ST_ENC_CHK  = 4'd4,
    ST_DEC_REQ  = 4'd5,
    ST_DEC_WAIT = 4'd6,
    ST_DEC_CHK  = 4'd7,
    ST_DONE     = 4'd8
  } state_e;

  localparam logic [127:0] KAT_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KAT_K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KAT_K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] KAT_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  // Lowest-index enabled key size; only meaningful when the mask is non-zero.
  function automatic keylen_e lowest_keylen(input logic [2:0] m);
    if (m[0]) begin
      return KL_128;
    end else if (m[1]) begin
      return KL_192;
    end else begin
      return KL_256;
    end
  endfunction

  function automatic logic [255:0] kat_key(input keylen_e kl);
    case (kl)
      KL_128:  return {KAT_K128, 128'h0};
      KL_192:  return {KAT_K192, 64'h0};
      KL_256:  return KAT_K256;
      default: return 256'h0;
    endcase
  endfunction

  function automatic logic [127:0] kat_ct(input keylen_e kl);
    case (kl)
      KL_128:  return KAT_CT128;
      KL_192:  return KAT_CT192;
      KL_256:  return KAT_CT256;
      default: return 128'h0;
    endcase
  endfunction

endpackage

// File: rtl/aes_selftest_if.sv
// Request/response bus between the self-test controller and the iterative
// AES core.
//   core_start   - one-cycle request pulse          (controller -> core)
//   core_decrypt - 0 encrypt, 1 decrypt             (controller -> core)
//   core_keylen  - 00=128, 01=192, 10=256           (controller -> core)
//   core_key     - MSB-justified key                (controller -> core)
//   core_in      - input block                      (controller -> core)
//   core_done    - one-cycle completion pulse       (core -> controller)
//   core_out     - result, valid with core_done     (core -> controller)
interface aes_selftest_if;
  logic         core_start;
  logic         core_decrypt;
  logic [1:0]   core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_in;
  logic         core_done;
  logic [127:0] core_out;

  modport master (
    output core_start, core_decrypt, core_keylen, core_key, core_in,
    input  core_done, core_out
  );

  modport slave (
    input  core_start, core_decrypt, core_keylen, core_key, core_in,
    output core_done, core_out
  );
endinterface

// File: rtl/aes_selftest_timer.sv
// Core response watchdog. Cleared while a request is issued, counts the
// cycles spent waiting, and flags the last permitted wait cycle so that a
// wait lasts at most TIMEOUT_CYCLES cycles.
//   clk, reset - clock, synchronous active-high reset
//   clear      - restart the count from zero
//   enable     - a waiting cycle is in progress
//   expired    - this waiting cycle is the TIMEOUT_CYCLES-th one
module aes_selftest_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_r;

  // Wait-cycle counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/aes_selftest_ctrl.sv
// AES built-in self-test controller. Walks the key sizes enabled in
// mode_mask (128, 192, 256 in that order), runs an encrypt and a decrypt of
// the FIPS-197 vectors on the shared core, and reports per-size results.
//   clk, reset  - clock, synchronous active-high reset
//   start       - level request, sampled in IDLE/DONE only
//   mode_mask   - bit0=128, bit1=192, bit2=256, sampled with start
//   core        - master side of the AES core bus
//   busy, done  - sequence running / finished (done held until next start)
//   pass, fail  - per-size result
//   timeout_err - any core timeout in the run
//   fail_count  - failed checks, saturating
// Build option AES_SELFTEST_LOOP_EN: while start stays high the sequence
// restarts after each DONE cycle; fail, timeout_err and fail_count then
// accumulate across those runs, pass is cleared per run.
module aes_selftest_ctrl
  import aes_selftest_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode_mask,
  aes_selftest_if.master   core,
  output logic             busy,
  output logic             done,
  output logic [2:0]       pass,
  output logic [2:0]       fail,
  output logic             timeout_err,
  output logic [CNT_W-1:0] fail_count
);

  state_e             state_r, state_s;
  logic [2:0]         mask_r, tested_r, cur_r, remain_s, pick_s;
  keylen_e            keylen_r;
  logic               decrypt_r, start_pulse_r, enc_bad_r;
  logic [255:0]       key_r;
  logic [127:0]       in_r, result_r;
  logic               busy_r, done_r, timeout_r;
  logic [2:0]         pass_r, fail_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               accept_s, keep_s, enc_bad_s, dec_bad_s;
  logic               tmr_clear_s, tmr_en_s, tmr_exp_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1'b1);
  endfunction

  assign remain_s    = mask_r & ~tested_r;
  assign pick_s      = remain_s & (~remain_s + 3'd1);   // isolate lowest set bit
  assign accept_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign enc_bad_s   = (result_r != kat_ct(keylen_r));
  assign dec_bad_s   = (result_r != KAT_PT);
  assign tmr_clear_s = (state_r == ST_ENC_REQ) || (state_r == ST_DEC_REQ);
  assign tmr_en_s    = (state_r == ST_ENC_WAIT) || (state_r == ST_DEC_WAIT);

`ifdef AES_SELFTEST_LOOP_EN
  logic loop_hold_r;

  // Remembers that start has stayed high since the run was accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      loop_hold_r <= 1'b0;
    end else if (accept_s) begin
      loop_hold_r <= 1'b1;
    end else if (!start) begin
      loop_hold_r <= 1'b0;
    end else begin
      loop_hold_r <= loop_hold_r;
    end
  end

  assign keep_s = (state_r == ST_DONE) && loop_hold_r;
`else
  assign keep_s = 1'b0;
`endif

  aes_selftest_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear_s),
    .enable  (tmr_en_s),
    .expired (tmr_exp_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; a done pulse in the last wait cycle beats the timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) state_s = ST_SEL;
        else       state_s = state_r;
      end
      ST_SEL: begin
        if (remain_s != 3'b000) state_s = ST_ENC_REQ;
        else                    state_s = ST_DONE;
      end
      ST_ENC_REQ:  state_s = ST_ENC_WAIT;
      ST_ENC_WAIT: begin
        if (core.core_done)  state_s = ST_ENC_CHK;
        else if (tmr_exp_s)  state_s = ST_SEL;
        else                 state_s = ST_ENC_WAIT;
      end
      ST_ENC_CHK:  state_s = ST_DEC_REQ;
      ST_DEC_REQ:  state_s = ST_DEC_WAIT;
      ST_DEC_WAIT: begin
        if (core.core_done)  state_s = ST_DEC_CHK;
        else if (tmr_exp_s)  state_s = ST_SEL;
        else                 state_s = ST_DEC_WAIT;
      end
      ST_DEC_CHK:  state_s = ST_SEL;
      default:     state_s = ST_IDLE;
    endcase
  end

  // Request data, result capture and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_r        <= 3'b000;
      tested_r      <= 3'b000;
      cur_r         <= 3'b000;
      keylen_r      <= KL_128;
      decrypt_r     <= 1'b0;
      start_pulse_r <= 1'b0;
      enc_bad_r     <= 1'b0;
      key_r         <= 256'h0;
      in_r          <= 128'h0;
      result_r      <= 128'h0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
      pass_r        <= 3'b000;
      fail_r        <= 3'b000;
      cnt_r         <= '0;
    end else begin
      start_pulse_r <= (state_s == ST_ENC_REQ) || (state_s == ST_DEC_REQ);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            mask_r   <= mode_mask;
            tested_r <= 3'b000;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            pass_r   <= 3'b000;
            if (!keep_s) begin
              fail_r    <= 3'b000;
              timeout_r <= 1'b0;
              cnt_r     <= '0;
            end
          end
        end
        ST_SEL: begin
          if (remain_s != 3'b000) begin
            tested_r  <= tested_r | pick_s;
            cur_r     <= pick_s;
            keylen_r  <= lowest_keylen(remain_s);
            key_r     <= kat_key(lowest_keylen(remain_s));
            in_r      <= KAT_PT;
            decrypt_r <= 1'b0;
            enc_bad_r <= 1'b0;
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        ST_ENC_WAIT, ST_DEC_WAIT: begin
          if (core.core_done) begin
            result_r <= core.core_out;
          end else if (tmr_exp_s) begin
            timeout_r <= 1'b1;
            fail_r    <= fail_r | cur_r;
            cnt_r     <= sat_inc(cnt_r);
          end
        end
        ST_ENC_CHK: begin
          if (enc_bad_s) begin
            enc_bad_r <= 1'b1;
            cnt_r     <= sat_inc(cnt_r);
          end
          // Decrypt the reference ciphertext, not whatever the core produced.
          in_r      <= kat_ct(keylen_r);
          decrypt_r <= 1'b1;
        end
        ST_DEC_CHK: begin
          if (dec_bad_s) begin
            cnt_r <= sat_inc(cnt_r);
          end
          // A sticky fail from an earlier looped run keeps pass clear.
          if (enc_bad_r || dec_bad_s) begin
            fail_r <= fail_r | cur_r;
          end else if ((fail_r & cur_r) == 3'b000) begin
            pass_r <= pass_r | cur_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign core.core_start   = start_pulse_r;
  assign core.core_decrypt = decrypt_r;
  assign core.core_keylen  = keylen_r;
  assign core.core_key     = key_r;
  assign core.core_in      = in_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign pass              = pass_r;
  assign fail              = fail_r;
  assign timeout_err       = timeout_r;
  assign fail_count        = cnt_r;

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Self-test bench for aes_selftest_ctrl: a behavioural AES core answering
// from the FIPS-197 vectors with per-transaction latency/corruption tables,
// and a per-run reference model of the expected results and request list.
module tb_aes_selftest_ctrl;
  localparam int T = 16;
  localparam logic [127:0] R_PT = 128'h00112233445566778899aabbccddeeff;

  logic [255:0] r_key [3];
  logic [127:0] r_ct  [3];

  logic       clk = 1'b0;
  logic       reset, start;
  logic [2:0] mode_mask;
  logic       busy, done, timeout_err;
  logic [2:0] pass, fail;
  logic [7:0] fail_count;

  aes_selftest_if bus();

  aes_selftest_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_mask(mode_mask),
    .core(bus), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout_err(timeout_err), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int lat_tab [3][2];
  logic [127:0] err_tab [3][2];
  bit cd_pend, spur;
  int cd_cnt;
  logic [127:0] cd_val;
  int q_kl[$], q_dec[$], q_cyc[$];
  logic [127:0] q_in[$];
  logic [255:0] q_key[$];
  logic [2:0] e_pass, e_fail;
  bit e_to;
  int e_cnt;
  int e_kl[$], e_dec[$];
  logic [127:0] e_in[$];
  int start_cyc, done_cyc;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: move past the edge, then play the core for the new cycle.
  task automatic step();
    int k, d;
    logic [127:0] good;
    @(posedge clk);
    #1;
    cyc++;
    bus.core_done = 1'b0;
    bus.core_out  = 128'h0;
    if (cd_pend) begin
      cd_cnt--;
      if (cd_cnt == 0) begin
        bus.core_done = 1'b1;
        bus.core_out  = cd_val;
        cd_pend = 1'b0;
      end
    end
    if (bus.core_start === 1'b1) begin
      k = (bus.core_keylen > 2'd2) ? 0 : int'(bus.core_keylen);
      d = int'(bus.core_decrypt);
      q_kl.push_back(int'(bus.core_keylen)); q_dec.push_back(d);
      q_in.push_back(bus.core_in); q_key.push_back(bus.core_key); q_cyc.push_back(cyc);
      if (d == 0) good = (bus.core_in == R_PT && bus.core_key == r_key[k]) ? r_ct[k] : ~bus.core_in;
      else        good = (bus.core_in == r_ct[k] && bus.core_key == r_key[k]) ? R_PT : ~bus.core_in;
      cd_val = good ^ err_tab[k][d];
      cd_cnt = lat_tab[k][d];
      cd_pend = 1'b1;
    end
    if (spur && !bus.core_done) begin
      bus.core_done = 1'b1;
      bus.core_out  = {4{$urandom}};
    end
    spur = 1'b0;
  endtask

  // Expected outcome of one run, straight from the self-test rules.
  task automatic predict(input logic [2:0] m);
    e_pass = 3'b000; e_fail = 3'b000; e_to = 1'b0; e_cnt = 0;
    e_kl.delete(); e_dec.delete(); e_in.delete();
    for (int k = 0; k < 3; k++) begin
      bit eb, db;
      if (!m[k]) continue;
      e_kl.push_back(k); e_dec.push_back(0); e_in.push_back(R_PT);
      if (lat_tab[k][0] > T) begin e_fail[k] = 1'b1; e_to = 1'b1; e_cnt++; continue; end
      eb = (err_tab[k][0] != 128'h0);
      if (eb) e_cnt++;
      e_kl.push_back(k); e_dec.push_back(1); e_in.push_back(r_ct[k]);
      if (lat_tab[k][1] > T) begin e_fail[k] = 1'b1; e_to = 1'b1; e_cnt++; continue; end
      db = (err_tab[k][1] != 128'h0);
      if (db) e_cnt++;
      if (eb || db) e_fail[k] = 1'b1; else e_pass[k] = 1'b1;
    end
  endtask

  task automatic set_tabs(input int lat);
    for (int k = 0; k < 3; k++)
      for (int d = 0; d < 2; d++) begin lat_tab[k][d] = lat; err_tab[k][d] = 128'h0; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);          chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 3'b000);        chk({tag, "_fail"}, fail, 3'b000);
    chk({tag, "_to"}, timeout_err, 1'b0);     chk({tag, "_cnt"}, fail_count, 8'h00);
    chk({tag, "_cstart"}, bus.core_start, 1'b0);
    chk({tag, "_cdec"}, bus.core_decrypt, 1'b0);
    chk({tag, "_ckl"}, bus.core_keylen, 2'b00);
    chk({tag, "_ckey"}, bus.core_key, 256'h0);
    chk({tag, "_cin"}, bus.core_in, 128'h0);
  endtask

  task automatic run(input string tag, input logic [2:0] m, input bit toggle, input bit spur_first);
    int n, ne;
    q_kl.delete(); q_dec.delete(); q_in.delete(); q_key.delete(); q_cyc.delete();
    mode_mask = m; start = 1'b1; spur = spur_first; start_cyc = cyc;
    step();
    chk({tag, "_busy_start"}, busy, 1'b1);
    chk({tag, "_done_clr"}, done, 1'b0);
    spur = spur_first;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      if (toggle) start = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    start = 1'b0;
    done_cyc = cyc;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_end"}, busy, 1'b0);
    predict(m);
    chk({tag, "_pass"}, pass, e_pass);
    chk({tag, "_fail"}, fail, e_fail);
    chk({tag, "_to"}, timeout_err, e_to);
    chk({tag, "_cnt"}, fail_count, 8'(e_cnt));
    chk({tag, "_nreq"}, q_kl.size(), e_kl.size());
    ne = (q_kl.size() < e_kl.size()) ? q_kl.size() : e_kl.size();
    for (int i = 0; i < ne; i++) begin
      chk($sformatf("%s_kl%0d", tag, i), q_kl[i], e_kl[i]);
      chk($sformatf("%s_dec%0d", tag, i), q_dec[i], e_dec[i]);
      chk($sformatf("%s_in%0d", tag, i), q_in[i], e_in[i]);
      chk($sformatf("%s_key%0d", tag, i), q_key[i], r_key[e_kl[i]]);
    end
  endtask

  initial begin
    int n;
    r_key[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    r_key[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    r_key[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    r_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    r_ct[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    r_ct[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;
    reset = 1'b1; start = 1'b0; mode_mask = 3'b000; spur = 1'b0; cd_pend = 1'b0; cd_cnt = 0;
    bus.core_done = 1'b0; bus.core_out = 128'h0;
    set_tabs(12);
    step(); step();
    chk_zero("rst");
    reset = 1'b0;
    step();
    chk_zero("idle");

    // All three sizes against a correct core.
    run("t1", 3'b111, 1'b0, 1'b0);
    // Corrupted 192 encrypt result.
    err_tab[1][0] = 128'h1;
    run("t2", 3'b010, 1'b0, 1'b0);
    set_tabs(12);
    // Core never answers: timeout after T wait cycles, then SEL, then DONE.
    lat_tab[0][0] = 1000;
    run("t3", 3'b001, 1'b0, 1'b0);
    if (q_cyc.size() > 0) chk("t3_latency", done_cyc - q_cyc[0], T + 2);
    // Done arriving in the last permitted wait cycle still counts.
    set_tabs(T);
    run("t3b", 3'b001, 1'b0, 1'b0);
    set_tabs(T + 1);
    run("t3c", 3'b100, 1'b0, 1'b0);
    set_tabs(12);
    // Empty mask.
    run("t4", 3'b000, 1'b0, 1'b0);
    chk("t4_latency", done_cyc - start_cyc, 2);

    // Reset in the middle of the 256 decrypt wait.
    reset = 1'b1; step(); reset = 1'b0; step();
    q_kl.delete(); q_dec.delete(); q_in.delete(); q_key.delete(); q_cyc.delete();
    mode_mask = 3'b100; start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (q_kl.size() < 2 && n < 200) begin step(); n++; end
    chk("t5_dec_issued", q_kl.size(), 2);
    step(); step(); step();
    reset = 1'b1; step();
    chk_zero("t5_rst");
    reset = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("t5_late_busy", busy, 1'b0);
    chk("t5_late_done", done, 1'b0);
    chk("t5_late_nreq", q_kl.size(), 2);
    run("t5b", 3'b100, 1'b0, 1'b0);

    // Spurious done in IDLE and SEL, start toggling while busy.
    reset = 1'b1; step(); reset = 1'b0; step();
    spur = 1'b1; step(); step();
    chk_zero("t6_idle_spur");
    spur = 1'b1; step();
    run("t6", 3'b111, 1'b1, 1'b1);

    // Randomized runs restarted back-to-back from DONE.
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 3; k++)
        for (int d = 0; d < 2; d++) begin
          lat_tab[k][d] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T + 1, T + 4))
                                                      : int'($urandom_range(1, T));
          err_tab[k][d] = ($urandom_range(0, 3) == 0) ? (128'h1 << $urandom_range(0, 127)) : 128'h0;
        end
      run($sformatf("rnd%0d", r), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef AES_SELFTEST_LOOP_EN
    begin
      int seen;
      set_tabs(12);
      err_tab[0][0] = 128'h80;
      mode_mask = 3'b001; start = 1'b1;
      seen = 0; n = 0;
      while (seen < 3 && n < 1000) begin
        step(); n++;
        if (done === 1'b1) begin
          seen++;
          chk($sformatf("loop_cnt%0d", seen), fail_count, 8'(seen));
          chk($sformatf("loop_fail%0d", seen), fail, 3'b001);
          chk($sformatf("loop_pass%0d", seen), pass, 3'b000);
        end
      end
      start = 1'b0;
      chk("loop_runs", seen, 3);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_selftest_ctrl.md
Name: aes_selftest_ctrl

Overview:
Sequential built-in self-test controller for the AES datapath. On request it walks the enabled key sizes (128/192/256), drives an iterative AES core through a start/done handshake for encrypt and then decrypt, and checks the results against FIPS-197 known-answer vectors. It reports per-key-size pass/fail, timeout and a failure count. It sits between the board-level control inputs (buttons/switches) and the shared AES core, replacing direct LED decode logic.

Parameters:
TIMEOUT_CYCLES, 1023, maximum cycles to wait for core_done after core_start; minimum 1.
CNT_W, 8, width of fail_count; saturates at all-ones.

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
start  in  1  level; sampled only in IDLE or DONE
mode_mask  in  3  bit0=128, bit1=192, bit2=256; sampled with start
core_start  out  1  single-cycle request pulse to the AES core
core_decrypt  out  1  0=encrypt, 1=decrypt
core_keylen  out  2  00=128, 01=192, 10=256
core_key  out  256  key, MSB-justified, unused LSBs zero
core_in  out  128  plaintext or ciphertext block
core_done  in  1  single-cycle completion pulse from the core
core_out  in  128  core result; valid when core_done=1
busy  out  1  test sequence in progress
done  out  1  sequence finished; held until next accepted start or reset
pass  out  3  per key size: encrypt and decrypt both matched
fail  out  3  per key size: mismatch or timeout
timeout_err  out  1  sticky; any core timeout in the current run
fail_count  out  CNT_W  number of failed checks (encrypt and decrypt counted separately), saturating

Behaviour:
- Reset: all outputs 0, core_key/core_in 0, FSM=IDLE, counters cleared. Applies mid-sequence with no core handshake completion.
- FSM: IDLE -> SEL -> ENC_REQ -> ENC_WAIT -> ENC_CHK -> DEC_REQ -> DEC_WAIT -> DEC_CHK -> SEL ... -> DONE.
- IDLE/DONE: start=1 latches mode_mask, clears pass/fail/timeout_err/fail_count/done, sets busy, and moves to SEL on the next cycle.
- SEL: picks the lowest-index enabled, untested key size. If none remain, goes to DONE (busy=0, done=1). mode_mask=000 gives DONE two cycles after start with pass=fail=0.
- ENC_REQ: core_start=1 for exactly one cycle; core_decrypt=0; core_in = PT; core_key/keylen from the package. core_* data is held stable from ENC_REQ until the matching check state.
- ENC_WAIT: the timeout counter is cleared at REQ and increments each cycle. core_done captures core_out, then ENC_CHK. If the counter reaches TIMEOUT_CYCLES first: set timeout_err and fail[i], increment fail_count, skip the decrypt for this size, and return to SEL.
- ENC_CHK: compares against expected CT[i]; a mismatch sets an encrypt-fail flag and increments fail_count. Decrypt always runs using the expected CT[i] as input, not the captured output.
- DEC_REQ/DEC_WAIT/DEC_CHK: same handshake with core_decrypt=1; the result is compared to PT. At DEC_CHK, pass[i] = no enc fail and no dec fail; otherwise fail[i]. pass[i] and fail[i] are never both 1.
- core_done outside the WAIT states is ignored. core_done in the same cycle as a timeout: done wins.
- start held high while busy is ignored. Held high in DONE, it restarts.
- fail_count saturates at 2^CNT_W-1.

Optional Feature:
AES_SELFTEST_LOOP_EN:
- Defined: after DONE (one cycle with done=1), the sequence automatically restarts while start remains 1. pass is cleared per run. fail, timeout_err and fail_count accumulate across runs (sticky until reset or start deassert then reassert).
- Undefined: single run per accepted start, as above.

Decomposition:
- Package aes_selftest_pkg: keylen enum (KL_128/KL_192/KL_256), FSM state enum, known-answer constants:
  - PT = 00112233445566778899aabbccddeeff
  - K128 = 000102..0f, CT128 = 69c4e0d86a7b0430d8cdb78070b4c55a
  - K192 = 000102..17, CT192 = dda97ca4864cdfe06eaf70a0ec0d7191
  - K256 = 000102..1f, CT256 = 8ea2b7ca516745bfeafc49904b496089
- One natural sub-module: aes_selftest_timer (load/clear, enable, terminal-count flag).

Test Plan:
1. Reset, then start=1 for one cycle with mode_mask=111, using a correct core model (fixed latency 12) -> six core_start pulses in keylen order 00,00,01,01,10,10; pass=111, fail=000, fail_count=0, done=1, busy=0.
2. mode_mask=010, core model corrupts bit0 of the 192 encrypt output -> fail=010, pass=000, fail_count=1, decrypt still issued with core_in=dda97ca4...7191.
3. mode_mask=001, core never asserts done, TIMEOUT_CYCLES=16 -> fail=001, timeout_err=1, only one core_start, done asserted 16 cycles after ENC_REQ plus FSM overhead.
4. mode_mask=000 -> done=1 two cycles after start, no core_start, pass=fail=0.
5. Assert reset during DEC_WAIT of 256 -> next cycle all outputs 0, FSM IDLE, late core_done ignored. A fresh start with mask=100 passes.
6. Spurious core_done in SEL/IDLE and start toggled while busy -> no state change, results identical to scenario 1. With AES_SELFTEST_LOOP_EN and start held -> repeated runs, fail_count accumulates under an injected fault.
